// File: rtl/imem_load_ctrl.sv
// Shares the instruction-memory port between a streaming program loader and the core fetch path.
// After reset the core is held stalled until an image is loaded or a bare run is requested.
module imem_load_ctrl #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic          run_start,
    input  logic          ld_valid,
    input  logic [31:0]   ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    input  logic [31:0]   fetch_A,
    output logic [31:0]   fetch_RD,
    output logic          core_stall,
    output logic          fetch_misalign,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          load_done,
    output logic [AW:0]   load_count,
    output logic          err_overflow
);

    localparam logic [1:0]  StIdle = 2'd0;
    localparam logic [1:0]  StLoad = 2'd1;
    localparam logic [1:0]  StRun  = 2'd2;
    localparam logic [31:0] Nop    = 32'h00000013;

    localparam logic [AW:0] LastAddr = (AW + 1)'(DEPTH - 1);
    localparam logic [AW:0] CountOne = (AW + 1)'(1);

    logic [1:0]  state_q, state_d;
    logic [AW:0] load_count_q, load_count_d;
    logic        err_overflow_q, err_overflow_d;
    logic        load_done_q, load_done_d;

    logic accept;
    logic in_run;
    logic out_of_range;

    assign in_run       = (state_q == StRun);
    assign ld_ready     = (state_q == StLoad);
    assign accept       = ld_valid && ld_ready;
    assign core_stall   = !in_run;
    assign out_of_range = ((fetch_A >> (AW + 2)) != 32'd0);

    assign load_done    = load_done_q;
    assign load_count   = load_count_q;
    assign err_overflow = err_overflow_q;

    always_comb begin
        mem_we         = accept;
        mem_wdata      = accept ? ld_data : 32'd0;
        mem_addr       = '0;
        fetch_RD       = Nop;
        fetch_misalign = 1'b0;
        case (state_q)
            StLoad: mem_addr = load_count_q[AW-1:0];
            StRun: begin
                mem_addr       = fetch_A[AW+1:2];
                fetch_misalign = (fetch_A[1:0] != 2'b00);
                if (!fetch_misalign && !out_of_range) begin
                    fetch_RD = mem_rdata;
                end
            end
            default: mem_addr = '0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        load_count_d   = load_count_q;
        err_overflow_d = err_overflow_q;
        load_done_d    = 1'b0;
        case (state_q)
            StIdle: begin
                if (load_start) begin
                    state_d        = StLoad;
                    load_count_d   = '0;
                    err_overflow_d = 1'b0;
                end else if (run_start) begin
                    state_d = StRun;
                end
            end
            StLoad: begin
                if (accept) begin
                    load_count_d = load_count_q + CountOne;
                    // The last memory slot ends the load even without ld_last.
                    if (ld_last || (load_count_q == LastAddr)) begin
                        state_d     = StRun;
                        load_done_d = 1'b1;
                    end
                    if (!ld_last && (load_count_q == LastAddr)) begin
                        err_overflow_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (load_start) begin
                    state_d        = StLoad;
                    load_count_d   = '0;
                    err_overflow_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= StIdle;
            load_count_q   <= '0;
            err_overflow_q <= 1'b0;
            load_done_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            load_count_q   <= load_count_d;
            err_overflow_q <= err_overflow_d;
            load_done_q    <= load_done_d;
        end
    end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Bench for imem_load_ctrl: expected memory writes go to a queue checked by a write monitor,
// other outputs are compared directly against hand-computed values.
module tb_imem_load_ctrl;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned AW    = 10;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_start, run_start;
    logic          ld_valid, ld_last, ld_ready;
    logic [31:0]   ld_data;
    logic [31:0]   fetch_A, fetch_RD;
    logic          core_stall, fetch_misalign;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic          load_done, err_overflow;
    logic [AW:0]   load_count;

    logic [31:0]   mem [0:DEPTH-1];
    logic [41:0]   exp_q [$];
    int            checks   = 0;
    int            failures = 0;
    int unsigned   exp_addr;

    always #5 clk = ~clk;

    imem_load_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .load_start     (load_start),
        .run_start      (run_start),
        .ld_valid       (ld_valid),
        .ld_data        (ld_data),
        .ld_last        (ld_last),
        .ld_ready       (ld_ready),
        .fetch_A        (fetch_A),
        .fetch_RD       (fetch_RD),
        .core_stall     (core_stall),
        .fetch_misalign (fetch_misalign),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .load_done      (load_done),
        .load_count     (load_count),
        .err_overflow   (err_overflow)
    );

    // Instruction memory array: synchronous write, combinational read.
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    // Write monitor: every DUT write must match the next expected {addr, data}.
    always @(negedge clk) begin
        if (mem_we) begin
            logic [41:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL write_unexpected addr=%0d data=%h expected=none", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_wdata} !== e) begin
                    failures++;
                    $display("FAIL write got addr=%0d data=%h expected addr=%0d data=%h",
                             mem_addr, mem_wdata, e[41:32], e[31:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        exp_addr   = 0;
    endtask

    // One valid beat that the controller must accept.
    task automatic beat(input logic [31:0] data, input logic last);
        ld_valid = 1'b1;
        ld_data  = data;
        ld_last  = last;
        exp_q.push_back({exp_addr[AW-1:0], data});
        exp_addr++;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic idle_cycle();
        ld_valid = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b0; load_start = 1'b0; run_start = 1'b0;
        ld_valid = 1'b0; ld_data = 32'd0; ld_last = 1'b0; fetch_A = 32'd0;
        tick();
        tick();
        rst = 1'b1;

        // Reset values
        chk("rst_core_stall", {31'd0, core_stall}, 32'd1);
        chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_load_done", {31'd0, load_done}, 32'd0);
        chk("rst_load_count", {21'd0, load_count}, 32'd0);
        chk("rst_err_overflow", {31'd0, err_overflow}, 32'd0);
        chk("rst_fetch_RD", fetch_RD, NOP);
        chk("rst_fetch_misalign", {31'd0, fetch_misalign}, 32'd0);

        // Basic three-word load
        start_load();
        chk("load_ld_ready", {31'd0, ld_ready}, 32'd1);
        chk("load_core_stall", {31'd0, core_stall}, 32'd1);
        beat(32'hFFC4A303, 1'b0);
        beat(32'h0064A423, 1'b0);
        beat(32'h0062E233, 1'b1);
        chk("t1_load_done", {31'd0, load_done}, 32'd1);
        chk("t1_core_stall", {31'd0, core_stall}, 32'd0);
        chk("t1_load_count", {21'd0, load_count}, 32'd3);
        chk("t1_ld_ready", {31'd0, ld_ready}, 32'd0);
        fetch_A = 32'h8;
        #1 chk("t1_fetch_8", fetch_RD, 32'h0062E233);
        tick();
        chk("t1_load_done_pulse", {31'd0, load_done}, 32'd0);
        fetch_A = 32'h0;
        #1 chk("t1_fetch_0", fetch_RD, 32'hFFC4A303);

        // Misaligned and out-of-range fetches
        fetch_A = 32'h6;
        #1 chk("misalign_flag", {31'd0, fetch_misalign}, 32'd1);
        chk("misalign_nop", fetch_RD, NOP);
        fetch_A = 32'h00001000;
        #1 chk("oor_nop", fetch_RD, NOP);
        chk("oor_misalign", {31'd0, fetch_misalign}, 32'd0);
        fetch_A = 32'h4;
        #1 chk("fetch_4", fetch_RD, 32'h0064A423);

        // Reload from RUN with ld_valid gaps
        start_load();
        chk("reload_count_clr", {21'd0, load_count}, 32'd0);
        beat(32'h11111111, 1'b0);
        idle_cycle();
        idle_cycle();
        chk("gap_count", {21'd0, load_count}, 32'd1);
        beat(32'h22222222, 1'b0);
        beat(32'h33333333, 1'b1);
        chk("gap_load_count", {21'd0, load_count}, 32'd3);
        chk("gap_load_done", {31'd0, load_done}, 32'd1);
        fetch_A = 32'h8;
        #1 chk("gap_fetch_8", fetch_RD, 32'h33333333);

        // load_start and run_start together in IDLE: load wins
        do_reset();
        load_start = 1'b1;
        run_start  = 1'b1;
        tick();
        load_start = 1'b0;
        run_start  = 1'b0;
        exp_addr   = 0;
        chk("both_ld_ready", {31'd0, ld_ready}, 32'd1);
        chk("both_core_stall", {31'd0, core_stall}, 32'd1);

        // Reset mid-load after two beats
        beat(32'hAAAA0000, 1'b0);
        beat(32'hAAAA0001, 1'b0);
        chk("mid_load_count", {21'd0, load_count}, 32'd2);
        do_reset();
        chk("midrst_load_count", {21'd0, load_count}, 32'd0);
        chk("midrst_core_stall", {31'd0, core_stall}, 32'd1);
        chk("midrst_ld_ready", {31'd0, ld_ready}, 32'd0);

        // run_start alone: RUN without loading, partial words still in memory
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
        chk("run_core_stall", {31'd0, core_stall}, 32'd0);
        chk("run_load_count", {21'd0, load_count}, 32'd0);
        chk("run_load_done", {31'd0, load_done}, 32'd0);
        fetch_A = 32'h4;
        #1 chk("run_fetch_partial", fetch_RD, 32'hAAAA0001);

        // Single-word reload overwrites mem[0] only
        start_load();
        beat(32'hBBBBBBBB, 1'b1);
        chk("one_load_count", {21'd0, load_count}, 32'd1);
        fetch_A = 32'h0;
        #1 chk("one_fetch_0", fetch_RD, 32'hBBBBBBBB);
        fetch_A = 32'h4;
        #1 chk("one_fetch_4", fetch_RD, 32'hAAAA0001);

        // Overflow: stream DEPTH+2 words with no ld_last
        start_load();
        for (int i = 0; i < DEPTH + 2; i++) begin
            ld_valid = 1'b1;
            ld_last  = 1'b0;
            ld_data  = 32'hC0DE0000 ^ i;
            if (i < DEPTH) begin
                exp_q.push_back({exp_addr[AW-1:0], ld_data});
                exp_addr++;
            end
            tick();
            if (i == DEPTH - 1) begin
                chk("ovf_load_done", {31'd0, load_done}, 32'd1);
                chk("ovf_err", {31'd0, err_overflow}, 32'd1);
                chk("ovf_ld_ready", {31'd0, ld_ready}, 32'd0);
                chk("ovf_load_count", {21'd0, load_count}, DEPTH);
            end
        end
        ld_valid = 1'b0;
        chk("ovf_ld_ready_after", {31'd0, ld_ready}, 32'd0);
        chk("ovf_err_sticky", {31'd0, err_overflow}, 32'd1);
        chk("ovf_count_hold", {21'd0, load_count}, DEPTH);
        fetch_A = 32'hFFC;
        #1 chk("ovf_fetch_last", fetch_RD, 32'hC0DE0000 ^ (DEPTH - 1));

        // Entering LOAD clears the overflow flag
        start_load();
        chk("reload_err_clr", {31'd0, err_overflow}, 32'd0);
        beat(32'h00000093, 1'b1);

        tick();
        tick();
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_load_ctrl.md
# imem_load_ctrl

Controller that owns the single write/read port of the core's instruction memory and shares it between a program loader (streaming valid/ready word interface) and the core's combinational fetch path. After reset it holds the core stalled, accepts a program image word-by-word into consecutive memory locations, then hands the port to the fetch path. It sits between the instruction memory array, the fetch stage of the single-cycle RISC-V core, and the host/debug load interface.

## Interface
- DEPTH, 1024, instruction memory size in 32-bit words (power of two)
- AW, 10, word-address width, log2(DEPTH)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset
- load_start  in  1  request to (re)load program image
- run_start  in  1  request to start core without loading
- ld_valid  in  1  loader word valid
- ld_data  in  32  loader word
- ld_last  in  1  qualifies ld_data as final word of image
- ld_ready  out  1  controller accepts loader word this cycle
- fetch_A  in  32  core PC (byte address)
- fetch_RD  out  32  instruction returned to core
- core_stall  out  1  core must hold PC and not commit
- fetch_misalign  out  1  fetch_A[1:0] != 0 while in RUN
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory word address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory combinational read data
- load_done  out  1  one-cycle pulse on LOAD→RUN
- load_count  out  AW+1  words written in last/current load
- err_overflow  out  1  sticky: image exceeded DEPTH

## Operation
- States: IDLE, LOAD, RUN. Reset → IDLE.
- IDLE: core_stall=1, ld_ready=0. load_start → LOAD (load_count cleared to 0, err_overflow cleared). run_start (without load_start) → RUN. Both asserted: load_start wins.
- LOAD: ld_ready=1. Beat accepted when ld_valid&ld_ready: mem_we=1, mem_addr=load_count[AW-1:0], mem_wdata=ld_data; load_count increments on that edge.
  - Accepted beat with ld_last=1 → RUN next cycle, load_done=1 for that one cycle.
  - Accepted beat at load_count==DEPTH-1 with ld_last=0 → word written, err_overflow set, → RUN, load_done pulses. Remaining loader words are not accepted.
  - load_start, run_start ignored in LOAD.
- RUN: core_stall=0, ld_ready=0, mem_we=0, mem_addr=fetch_A[AW+1:2], fetch_RD=mem_rdata.
  - fetch_A[31:AW+2] != 0 (out of range) → fetch_RD=32'h00000013 (NOP).
  - fetch_A[1:0] != 0 → fetch_misalign=1, fetch_RD=32'h00000013.
  - load_start → LOAD (reload; counters cleared as in IDLE). run_start ignored.
- Outside RUN: fetch_RD=32'h00000013, fetch_misalign=0, mem_addr driven by load_count (LOAD) or 0 (IDLE).
- Memory contents are never cleared by this block.

## Timing
- Reset values: state IDLE, core_stall=1, ld_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, load_done=0, load_count=0, err_overflow=0, fetch_RD=32'h00000013, fetch_misalign=0.
- ld_ready, core_stall, mem_we, mem_addr/wdata, fetch_RD, fetch_misalign are combinational from registered state and inputs; write commits on the clock edge of the accepted beat (memory write is synchronous).
- One word per cycle max; loader may drop ld_valid any cycle, no beat lost or duplicated.
- load_done is registered, asserted in the first RUN cycle only.
- Fetch in RUN: zero added latency (combinational address/data path).
- rst low mid-LOAD: next edge returns IDLE, counters/flags cleared, partially loaded words remain in memory.

## Test plan
- Reset, then load_start, stream 3 words 0xFFC4A303, 0x0064A423, 0x0062E233 (last on third) → mem[0..2] written, load_count=3, load_done one pulse, core_stall drops next cycle; fetch_A=0x8 → fetch_RD=0x0062E233.
- Loader with ld_valid gaps (valid 1,0,0,1,1 last) → exactly 3 writes at addresses 0,1,2, no duplicates.
- DEPTH=4, stream 6 words without ld_last → 4 writes, err_overflow=1, RUN entered, ld_ready=0 thereafter.
- RUN with fetch_A=0x6 → fetch_misalign=1, fetch_RD=0x00000013; fetch_A=0x00001000 (DEPTH=1024) → fetch_RD=0x00000013.
- Assert load_start and run_start together in IDLE → LOAD; run_start alone → RUN with load_count=0.
- rst low after 2 accepted beats → IDLE, load_count=0, core_stall=1; reload of 1 word with ld_last overwrites mem[0] only.
